// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned RF_ZERO_ADDR = 0;

  // Default core widths; the top re-declares the same shape at its own XLEN/AW.
  localparam int unsigned RF_XLEN = 32;
  localparam int unsigned RF_AW   = 5;

  typedef struct packed {
    logic [RF_AW-1:0]   addr;
    logic [RF_XLEN-1:0] data;
    logic               pend;
  } rf_rd_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with set-over-clear priority, a flush-all input
// and a same-cycle lookahead for every read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   set_en_i,
  input  logic [AW-1:0]          set_addr_i,
  input  logic                   clr_en_i,
  input  logic [AW-1:0]          clr_addr_i,
  input  logic [NRD-1:0][AW-1:0] rd_addr_i,
  output logic [NRD-1:0]         pend_o
);

  localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_ADDR);

  logic [NREGS-1:0] pend_q, pend_d;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
      // Applied after the clear so a producer issuing in the writeback cycle wins.
      if (set_en_i && set_addr_i != ZERO) pend_d[set_addr_i] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    pend_o = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rd_addr_i[p] != ZERO) begin
        pend_o[p] = (pend_q[rd_addr_i[p]] && !(clr_en_i && clr_addr_i == rd_addr_i[p]))
                    || (set_en_i && set_addr_i == rd_addr_i[p]);
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file: x0 hardwired, write-to-read bypass,
// pending scoreboard and a one-register-per-cycle clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           pend_o,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [XLEN-1:0]          wr_data_i,
  input  logic                     issue_en_i,
  input  logic [AW-1:0]            issue_addr_i,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o
);

  localparam logic [AW-1:0] ZERO     = AW'(RF_ZERO_ADDR);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            pend;
  } rd_port_t;

  logic [XLEN-1:0] regs_q [NREGS];
  rf_state_e       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            flush;
  logic            idle;
  logic            wr_ok;
  logic            iss_ok;
  logic [NRD-1:0]  sb_pend;
  rd_port_t [NRD-1:0] rd_port;

  assign idle       = (state_q == RF_IDLE);
  assign wr_ok      = idle && wr_en_i;
  assign iss_ok     = idle && issue_en_i;
  assign clr_busy_o = !idle;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flush   = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          idx_d   = AW'(1);
          flush   = 1'b1;
        end
      end
      RF_CLEAR: begin
        if (idx_q == IDX_LAST) begin
          state_d = RF_IDLE;
          idx_d   = AW'(1);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: this array is reset on purpose: reset must leave every register
  // reading zero. A storage array without that requirement should not be reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (!idle) begin
      regs_q[idx_q] <= '0;
    end else if (wr_en_i && wr_addr_i != ZERO) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .set_en_i   (iss_ok),
    .set_addr_i (issue_addr_i),
    .clr_en_i   (wr_ok),
    .clr_addr_i (wr_addr_i),
    .rd_addr_i  (rd_addr_i),
    .pend_o     (sb_pend)
  );

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_port[p].addr = rd_addr_i[p];
      rd_port[p].pend = sb_pend[p];
      if (rd_addr_i[p] == ZERO)                           rd_port[p].data = '0;
      else if (wr_ok && wr_addr_i == rd_addr_i[p])        rd_port[p].data = wr_data_i;
      else                                                rd_port[p].data = regs_q[rd_addr_i[p]];
      rd_data_o[p] = rd_port[p].data;
      pend_o[p]    = rd_port[p].pend;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors, clear/reset sequences and random
// traffic against a behavioural model, plus a 4-port 64-bit 16-entry instance.
module tb_regfile_mp;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic clk;
  logic rst_n;

  logic [NP-1:0][AW-1:0] rd_addr;
  logic [NP-1:0][XL-1:0] rd_data;
  logic [NP-1:0]         pend;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XL-1:0]         wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic                  clr_req;
  logic                  busy;

  logic [3:0][3:0]  b_rd_addr;
  logic [3:0][63:0] b_rd_data;
  logic [3:0]       b_pend;
  logic             b_wr_en;
  logic [3:0]       b_wr_addr;
  logic [63:0]      b_wr_data;
  logic             b_iss_en;
  logic [3:0]       b_iss_addr;
  logic             b_clr_req;
  logic             b_busy;

  regfile_mp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .pend_o       (pend),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .issue_en_i   (iss_en),
    .issue_addr_i (iss_addr),
    .clr_req_i    (clr_req),
    .clr_busy_o   (busy)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) dut_w (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr_i    (b_rd_addr),
    .rd_data_o    (b_rd_data),
    .pend_o       (b_pend),
    .wr_en_i      (b_wr_en),
    .wr_addr_i    (b_wr_addr),
    .wr_data_i    (b_wr_data),
    .issue_en_i   (b_iss_en),
    .issue_addr_i (b_iss_addr),
    .clr_req_i    (b_clr_req),
    .clr_busy_o   (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  int n_checks;
  int n_errors;

  // Behavioural model of the default instance: architectural state only.
  logic [XL-1:0] m_regs [NR];
  bit            m_pend [NR];
  bit            m_busy;
  int            m_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [XL-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (!m_busy && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_pend(input logic [AW-1:0] a);
    if (m_busy || a == 0) return 1'b0;
    return (m_pend[a] && !(wr_en && wr_addr == a)) || (iss_en && iss_addr == a);
  endfunction

  task automatic check_model(input string tag);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s rd_data[%0d] x%0d", tag, p, rd_addr[p]), 64'(rd_data[p]), 64'(exp_data(rd_addr[p])));
      check($sformatf("%s pend[%0d] x%0d", tag, p, rd_addr[p]), 64'(pend[p]), 64'(exp_pend(rd_addr[p])));
    end
    check($sformatf("%s clr_busy", tag), 64'(busy), 64'(m_busy));
  endtask

  task automatic mdl_step();
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_idx  = 1;
    end else if (m_busy) begin
      m_regs[m_idx] = '0;
      if (m_idx == NR - 1) m_busy = 1'b0;
      else                 m_idx++;
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      if (clr_req) begin
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        m_busy = 1'b1;
        m_idx  = 1;
      end else begin
        if (wr_en) m_pend[wr_addr] = 1'b0;
        if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en   = 1'b0; wr_addr  = '0; wr_data = '0;
    iss_en  = 1'b0; iss_addr = '0; clr_req = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_iss_en = 1'b0; b_iss_addr = '0; b_clr_req = 1'b0;
  endtask

  function automatic logic [63:0] bval(input int i);
    return {32'hA500_0000 + 32'(i), (32'(i) * 32'h0101_0101) ^ 32'h5A5A_5A5A};
  endfunction

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [XL-1:0] wd;
    logic          ie;
    logic [AW-1:0] ia;
    logic [AW-1:0] r0, r1;
    logic [XL-1:0] e0, e1;
    logic          ep0, ep1;
  } vec_t;

  vec_t        vecs [12];
  logic [63:0] b_mem [16];
  int          cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_in();
    rd_addr   = '0;
    b_rd_addr = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state: every address reads zero on both ports, nothing pending.
    for (int a = 0; a < NR; a++) begin
      rd_addr[0] = AW'(a);
      rd_addr[1] = AW'(NR - 1 - a);
      #3;
      check($sformatf("reset x%0d port0", a), 64'(rd_data[0]), 64'h0);
      check($sformatf("reset x%0d port1", NR - 1 - a), 64'(rd_data[1]), 64'h0);
      check($sformatf("reset pend x%0d", a), 64'(pend), 64'h0);
      check("reset clr_busy", 64'(busy), 64'h0);
      tick();
    end

    //           we  wa  wd             ie  ia  r0  r1  e0             e1             ep0 ep1
    vecs[0]  = '{1, 5,  32'hDEADBEEF,  0,  0,  5,  0,  32'hDEADBEEF,  32'h0,         0,  0};
    vecs[1]  = '{0, 0,  32'h0,         0,  0,  5,  7,  32'hDEADBEEF,  32'h0,         0,  0};
    vecs[2]  = '{1, 0,  32'h1234,      0,  0,  0,  5,  32'h0,         32'hDEADBEEF,  0,  0};
    vecs[3]  = '{0, 0,  32'h0,         0,  0,  0,  0,  32'h0,         32'h0,         0,  0};
    vecs[4]  = '{0, 0,  32'h0,         1,  7,  7,  5,  32'h0,         32'hDEADBEEF,  1,  0};
    vecs[5]  = '{0, 0,  32'h0,         0,  0,  7,  0,  32'h0,         32'h0,         1,  0};
    vecs[6]  = '{1, 7,  32'h77,        0,  0,  7,  7,  32'h77,        32'h77,        0,  0};
    vecs[7]  = '{0, 0,  32'h0,         0,  0,  7,  5,  32'h77,        32'hDEADBEEF,  0,  0};
    vecs[8]  = '{1, 7,  32'h88,        1,  7,  7,  7,  32'h88,        32'h88,        1,  1};
    vecs[9]  = '{0, 0,  32'h0,         0,  0,  7,  7,  32'h88,        32'h88,        1,  1};
    vecs[10] = '{0, 0,  32'h0,         1,  0,  0,  7,  32'h0,         32'h88,        0,  1};
    vecs[11] = '{1, 7,  32'h99,        0,  0,  7,  0,  32'h99,        32'h0,         0,  0};

    for (int v = 0; v < 12; v++) begin
      wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
      iss_en = vecs[v].ie; iss_addr = vecs[v].ia;
      rd_addr[0] = vecs[v].r0; rd_addr[1] = vecs[v].r1;
      #3;
      check($sformatf("vec%0d rd0", v), 64'(rd_data[0]), 64'(vecs[v].e0));
      check($sformatf("vec%0d rd1", v), 64'(rd_data[1]), 64'(vecs[v].e1));
      check($sformatf("vec%0d pend0", v), 64'(pend[0]), 64'(vecs[v].ep0));
      check($sformatf("vec%0d pend1", v), 64'(pend[1]), 64'(vecs[v].ep1));
      tick();
    end
    idle_in();

    // Load x1..x31 with their index, then sweep them away with a clear.
    for (int i = 1; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = XL'(i);
      rd_addr[0] = AW'(i); rd_addr[1] = AW'(i - 1);
      #3;
      check_model("load");
      tick();
    end
    idle_in();
    clr_req = 1'b1;
    #3;
    check("clr accept cycle busy", 64'(busy), 64'h0);
    tick();
    clr_req = 1'b0;

    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      wr_en = (cnt == 0 || cnt == 20); wr_addr = 5'd3; wr_data = 32'h55;
      iss_en = (cnt == 5); iss_addr = 5'd9;
      rd_addr[0] = 5'd3; rd_addr[1] = (cnt == 5) ? 5'd9 : AW'($urandom);
      #3;
      if (!busy) break;
      cnt++;
      if (cnt == 1) check("clear disables bypass x3", 64'(rd_data[0]), 64'h3);
      if (cnt == 6) check("clear drops issue pend x9", 64'(pend[1]), 64'h0);
      check_model("clear");
      tick();
    end
    check("clear busy cycles", 64'(cnt), 64'd31);

    // First IDLE cycle after the sweep: writes are accepted again.
    idle_in();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC0FFEE;
    rd_addr[0] = 5'd12; rd_addr[1] = 5'd3;
    #1;
    check("post-clear bypass x12", 64'(rd_data[0]), 64'hC0FFEE);
    tick();
    idle_in();
    for (int a = 0; a < NR; a++) begin
      rd_addr[0] = AW'(a);
      rd_addr[1] = 5'd3;
      #3;
      if (a != 12) check($sformatf("post-clear x%0d", a), 64'(rd_data[0]), 64'h0);
      else         check("post-clear x12 written", 64'(rd_data[0]), 64'hC0FFEE);
      check_model("post-clear");
      tick();
    end

    // Reset lands mid-sweep at idx 10 while x20 still holds 0xAA.
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hAA;
    tick();
    idle_in();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    rd_addr[0] = 5'd20; rd_addr[1] = 5'd12;
    for (int j = 0; j < 9; j++) begin
      #3;
      check_model("pre-reset sweep");
      tick();
    end
    rst_n = 1'b0;
    #3;
    check("mid-clear x20 before reset", 64'(rd_data[0]), 64'hAA);
    check("mid-clear busy before reset", 64'(busy), 64'h1);
    tick();
    rst_n = 1'b1;
    #3;
    check("after reset x20", 64'(rd_data[0]), 64'h0);
    check("after reset clr_busy", 64'(busy), 64'h0);
    check_model("after reset");
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr_en = 1'($urandom); wr_addr = AW'($urandom); wr_data = $urandom;
      iss_en = 1'($urandom); iss_addr = AW'($urandom);
      clr_req = ($urandom % 80 == 0);
      if (clr_req) iss_en = 1'b0;
      rd_addr[0] = ($urandom % 4 == 0) ? wr_addr : AW'($urandom);
      rd_addr[1] = ($urandom % 4 == 0) ? iss_addr : AW'($urandom);
      #3;
      check_model("rnd");
      tick();
    end
    idle_in();
    for (int k = 0; k < 100 && m_busy; k++) tick();

    // Wide instance: 4 ports, 64-bit data, 16 registers.
    for (int i = 0; i < 16; i++) b_mem[i] = '0;
    for (int i = 1; i < 16; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = bval(i);
      b_mem[i] = bval(i);
      tick();
    end
    b_wr_en = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (t == 0) begin
        b_rd_addr[0] = 4'd3; b_rd_addr[1] = 4'd7; b_rd_addr[2] = 4'd12; b_rd_addr[3] = 4'd15;
      end else begin
        for (int p = 0; p < 4; p++) b_rd_addr[p] = 4'($urandom);
      end
      #3;
      for (int p = 0; p < 4; p++) begin
        check($sformatf("wide rd%0d x%0d", p, b_rd_addr[p]), b_rd_data[p], b_mem[b_rd_addr[p]]);
      end
      check("wide pend", 64'(b_pend), 64'h0);
      tick();
    end
    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      #3;
      if (!b_busy) break;
      cnt++;
      tick();
    end
    check("wide clear busy cycles", 64'(cnt), 64'd15);
    tick();
    for (int a = 0; a < 16; a += 4) begin
      for (int p = 0; p < 4; p++) b_rd_addr[p] = 4'(a + p);
      #3;
      for (int p = 0; p < 4; p++) begin
        check($sformatf("wide post-clear x%0d", a + p), b_rd_data[p], 64'h0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
